fifo_param: RTL and testbench

Parametrised synchronous FIFO. Generalises the team's 8-bit/16-deep FIFO to arbitrary width and power-of-two depth. Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Used as the byte/word buffer between the UART RX/TX paths and the watch/stopwatch command controller.

---
 rtl/fifo_param_if.sv | 28 ++
 rtl/fifo_param.sv | 101 ++++++++++
 tb/tb_fifo_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - push/pop and status bundle for fifo_param
interface fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              clr_err;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, push_data, pop, clr_err,
        input  pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, clr_err,
        output pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with count, level flags and sticky errors (FIFO_OUTREG_EN: registered pop_data)
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input logic         clk,
    input logic         rst,
    fifo_param_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok, pop_ok;

    // Accept decisions, next pointers/count and sticky error updates from registered state
    always_comb begin
        push_ok     = bus.push & (~full_q | bus.pop);
        pop_ok      = bus.pop & ~empty_q;
        w_ptr_d     = push_ok ? w_ptr_q + PTR_ONE : w_ptr_q;
        r_ptr_d     = pop_ok ? r_ptr_q + PTR_ONE : r_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
        // A new error in the same cycle as clr_err wins
        overflow_d  = (overflow_q & ~bus.clr_err) | (bus.push & ~push_ok);
        underflow_d = (underflow_q & ~bus.clr_err) | (bus.pop & empty_q);
    end

    // Pointers, occupancy and flags; flags come from next-state count so they track count_q
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= AF_C);
            aempty_q    <= (count_d <= AE_C);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is not reset; a write on push+pop while full lands in the slot being freed
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[w_ptr_q] <= bus.push_data;
        end
    end

`ifdef FIFO_OUTREG_EN
    logic [DATA_W-1:0] pop_data_q;

    // Registered read port: head is captured on each accepted pop, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_q <= '0;
        end else if (pop_ok) begin
            pop_data_q <= mem_q[r_ptr_q];
        end
    end

    assign bus.pop_data = pop_data_q;
`else
    assign bus.pop_data = mem_q[r_ptr_q];
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param
module tb_fifo_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int         mcount = 0;
    bit         movf   = 1'b0;
    bit         munf   = 1'b0;
    logic [7:0] last_pop = 8'h00;

    typedef struct {
        bit         r;
        bit         p;
        logic [7:0] d;
        bit         o;
        bit         c;
        int         cnt;
        bit         full;
        bit         empty;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit p, input logic [7:0] d, input bit o, input bit c);
        bit         push_ok;
        bit         pop_ok;
        bit         ovf_ev;
        bit         unf_ev;
        logic [7:0] exp_head;
        exp_head      = 8'h00;
        rst           = r;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = o;
        bus.clr_err   = c;
        push_ok = !r && p && (mcount < DEPTH || o);
        pop_ok  = !r && o && (mcount != 0);
        ovf_ev  = !r && p && !push_ok;
        unf_ev  = !r && o && (mcount == 0);
        #1;
`ifndef FIFO_OUTREG_EN
        if (pop_ok) begin
            chk("pop_data_fwft", 32'(bus.pop_data), 32'(sb[0]));
            last_pop = bus.pop_data;
        end
`endif
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            mcount = 0;
            movf   = 1'b0;
            munf   = 1'b0;
        end else begin
            if (pop_ok) begin
                exp_head = sb.pop_front();
                mcount--;
            end
            if (push_ok) begin
                sb.push_back(d);
                mcount++;
            end
            movf = (movf && !c) || ovf_ev;
            munf = (munf && !c) || unf_ev;
        end
`ifdef FIFO_OUTREG_EN
        if (r) begin
            chk("pop_data_rst", 32'(bus.pop_data), 32'h0);
        end else if (pop_ok) begin
            chk("pop_data_reg", 32'(bus.pop_data), 32'(exp_head));
            last_pop = bus.pop_data;
        end
`endif
        chk("count",        32'(bus.count),        32'(mcount));
        chk("full",         32'(bus.full),         32'(mcount == DEPTH));
        chk("empty",        32'(bus.empty),        32'(mcount == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(mcount >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(mcount <= AE));
        chk("overflow",     32'(bus.overflow),     32'(movf));
        chk("underflow",    32'(bus.underflow),    32'(munf));
    endtask

    initial begin
        logic [7:0] v;
        tbl[0] = '{r:0, p:1, d:8'h3C, o:1, c:0, cnt:1, full:0, empty:0, ovf:0, unf:1};
        tbl[1] = '{r:0, p:0, d:8'h00, o:1, c:0, cnt:0, full:0, empty:1, ovf:0, unf:1};
        tbl[2] = '{r:0, p:0, d:8'h00, o:0, c:1, cnt:0, full:0, empty:1, ovf:0, unf:0};
        tbl[3] = '{r:0, p:0, d:8'h00, o:1, c:1, cnt:0, full:0, empty:1, ovf:0, unf:1};
        tbl[4] = '{r:0, p:0, d:8'h00, o:0, c:1, cnt:0, full:0, empty:1, ovf:0, unf:0};
        tbl[5] = '{r:0, p:1, d:8'h42, o:0, c:0, cnt:1, full:0, empty:0, ovf:0, unf:0};
        tbl[6] = '{r:0, p:1, d:8'h43, o:0, c:0, cnt:2, full:0, empty:0, ovf:0, unf:0};
        tbl[7] = '{r:0, p:1, d:8'h44, o:1, c:0, cnt:2, full:0, empty:0, ovf:0, unf:0};
        tbl[8] = '{r:1, p:1, d:8'h45, o:1, c:0, cnt:0, full:0, empty:1, ovf:0, unf:0};

        // Reset state
        step(1, 0, 8'h00, 0, 0);

        // Fill with 15 words then drain in order
        for (int i = 0; i < 15; i++) step(0, 1, 8'(8'h11 + i), 0, 0);
        chk("t1_count15", 32'(bus.count), 32'd15);
        chk("t1_af",      32'(bus.almost_full), 32'd1);
        chk("t1_not_full", 32'(bus.full), 32'd0);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0);
        chk("t1_last", 32'(last_pop), 32'h1F);
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // Fill to full, push into full FIFO, clear the error
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h01 + i), 0, 0);
        chk("t2_full", 32'(bus.full), 32'd1);
        step(0, 1, 8'hAA, 0, 0);
        chk("t2_ovf", 32'(bus.overflow), 32'd1);
        chk("t2_count", 32'(bus.count), 32'd16);
        step(0, 0, 8'h00, 0, 1);
        chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);

        // Push+pop while full, then drain
        step(0, 1, 8'h55, 1, 0);
        chk("t3_head", 32'(last_pop), 32'h01);
        chk("t3_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0);
        chk("t3_last", 32'(last_pop), 32'h55);

        // Table-driven: push+pop while empty, clr_err races, simultaneous ops, reset
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].p, tbl[i].d, tbl[i].o, tbl[i].c);
            chk($sformatf("tbl%0d_count", i), 32'(bus.count),     32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i),  32'(bus.full),      32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty),     32'(tbl[i].empty));
            chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i),   32'(bus.underflow), 32'(tbl[i].unf));
            if (i == 1) chk("tbl_pop_3c", 32'(last_pop), 32'h3C);
        end

        // Wrap-around with occupancy held at 3
        v = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, v, 0, 0);
            v++;
        end
        for (int i = 0; i < 40; i++) begin
            step(0, 1, v, 1, 0);
            v++;
            chk("t5_ae_low", 32'(bus.almost_empty), 32'd0);
        end
        chk("t5_count", 32'(bus.count), 32'd3);
        chk("t5_head_seen", 32'(last_pop), 32'd39);

        // Reset with 7 entries in flight
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
        chk("t6_count7", 32'(bus.count), 32'd7);
        step(1, 0, 8'h00, 0, 0);
        chk("t6_count0", 32'(bus.count), 32'd0);
        chk("t6_empty",  32'(bus.empty), 32'd1);
        step(0, 1, 8'h77, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t6_after_rst", 32'(last_pop), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
